shift_reg_bank: RTL and testbench

- Parametrised successor to the team's single-bit D storage element: a WIDTH-bit clocked register with hold, load, shift and rotate modes.
- Adds an autonomous multi-cycle shift sequencer (start/busy/done) for serialising words onto a one-bit line.
- Sits between parallel datapath logic and serial links or bit-level test fixtures.
- Edge-triggered only; no transparent (latch) behaviour.

---
 rtl/shift_reg_bank.sv | 124 ++++++++++++
 tb/tb_shift_reg_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_bank.sv
// WIDTH-bit register with hold/shift/rotate/load, plus a start/busy/done sequencer for n-step shifts.
// Single-step ops land on the sampling edge; a sequence of n steps ends with done in the cycle after edge k+n.
module shift_reg_bank #(
   parameter int unsigned     WIDTH     = 8,
   parameter int unsigned     SHW       = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             rot,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic [SHW-1:0]   shamt,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             dir_q, dir_d;   // 1 = left, 0 = right
   logic             rot_q, rot_d;
   logic             done_q, done_d;

   // One bit step; with rotation the bit leaving the register is the fill.
   function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                                input logic             left,
                                                input logic             r,
                                                input logic             sin);
      logic fill;
      if (left) begin
         fill    = r ? v[WIDTH-1] : sin;
         step_fn = {v[WIDTH-2:0], fill};
      end else begin
         fill    = r ? v[0] : sin;
         step_fn = {fill, v[WIDTH-1:1]};
      end
   endfunction

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      rot_d   = rot_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start && (mode == MODE_RIGHT || mode == MODE_LEFT)) begin
            if (shamt != '0) begin
               state_d = SHIFT;
               cnt_d   = shamt;
               dir_d   = (mode == MODE_LEFT);
               rot_d   = rot;
            end else begin
               done_d  = 1'b1;
            end
         end else if (en) begin
            case (mode)
               MODE_RIGHT: begin
                  q_d   = step_fn(q_q, 1'b0, rot, ser_in);
                  dir_d = 1'b0;
               end
               MODE_LEFT: begin
                  q_d   = step_fn(q_q, 1'b1, rot, ser_in);
                  dir_d = 1'b1;
               end
               MODE_LOAD: q_d = d;
               MODE_HOLD: q_d = q_q;
               default:   q_d = q_q;
            endcase
         end
      end else begin
         // Abort leaves the partial result in place and suppresses done.
         if (abort) begin
            state_d = IDLE;
         end else begin
            q_d   = step_fn(q_q, dir_q, rot_q, ser_in);
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         rot_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         rot_q   <= rot_d;
         done_q  <= done_d;
      end
   end

   assign q       = q_q;
   assign ser_out = dir_q ? q_q[WIDTH-1] : q_q[0];
   assign busy    = (state_q == SHIFT);
   assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed bench for shift_reg_bank: single steps, sequenced shifts, abort, back-to-back and async reset.
module tb_shift_reg_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic       rot;
   logic       ser_in;
   logic [7:0] d;
   logic       start;
   logic [3:0] shamt;
   logic       abort;
   logic [7:0] q;
   logic       ser_out;
   logic       busy;
   logic       done;

   int n_cmp  = 0;
   int n_fail = 0;

   shift_reg_bank #(.WIDTH(8), .SHW(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .rot(rot), .ser_in(ser_in),
      .d(d), .start(start), .shamt(shamt), .abort(abort),
      .q(q), .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled just after the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input logic [7:0] v);
      en = 1'b1; mode = 2'b11; d = v; start = 1'b0; abort = 1'b0;
      tick();
      en = 1'b0; mode = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hA5;
      start = 1'b0; shamt = '0; abort = 1'b0; rot = 1'b0; ser_in = 1'b0;
      tick(); tick();
      n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_release_load got=%h exp=a5", q); end
      en = 1'b0; mode = 2'b00;
   endtask

   task automatic test_single_step();
      load(8'h81);
      en = 1'b1; rot = 1'b0; mode = 2'b01; ser_in = 1'b0;
      tick();
      n_cmp++; if (q !== 8'h40) begin n_fail++; $display("FAIL ss_right got=%h exp=40", q); end
      n_cmp++; if (ser_out !== 1'b0) begin n_fail++; $display("FAIL ss_right_serout got=%b exp=0", ser_out); end
      mode = 2'b10; ser_in = 1'b1;
      tick();
      n_cmp++; if (q !== 8'h81) begin n_fail++; $display("FAIL ss_left got=%h exp=81", q); end
      n_cmp++; if (ser_out !== 1'b1) begin n_fail++; $display("FAIL ss_left_serout got=%b exp=1", ser_out); end
      en = 1'b0; mode = 2'b11; d = 8'h00;
      tick();
      n_cmp++; if (q !== 8'h81) begin n_fail++; $display("FAIL ss_hold got=%h exp=81", q); end
      mode = 2'b00; ser_in = 1'b0;
   endtask

   task automatic test_seq_rotate();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h08;
      load(8'h01);
      start = 1'b1; mode = 2'b10; rot = 1'b1; shamt = 4'd3;
      tick();
      start = 1'b0; mode = 2'b00; rot = 1'b0;
      n_cmp++; if (q !== 8'h01 || busy !== 1'b1 || done !== 1'b0) begin
         n_fail++; $display("FAIL rot_start got q=%h busy=%b done=%b exp q=01 busy=1 done=0", q, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL rot_step%0d got=%h exp=%h", i, q, exp_q[i]); end
         n_cmp++; if (busy !== (i < 2) || done !== (i == 2)) begin
            n_fail++; $display("FAIL rot_flags%0d got busy=%b done=%b", i, busy, done);
         end
      end
      tick();
      n_cmp++; if (done !== 1'b0 || q !== 8'h08) begin
         n_fail++; $display("FAIL rot_after got done=%b q=%h exp done=0 q=08", done, q);
      end
   endtask

   task automatic test_seq_wrap();
      logic [7:0] ff;
      ff = 8'hFF;
      load(8'hFF);
      start = 1'b1; mode = 2'b01; rot = 1'b0; ser_in = 1'b0; shamt = 4'd10;
      tick();
      start = 1'b0; mode = 2'b00;
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy got=%b exp=1", busy); end
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_cmp++; if (q !== (ff >> i)) begin n_fail++; $display("FAIL wrap_step%0d got=%h exp=%h", i, q, ff >> i); end
         n_cmp++; if (done !== (i == 10) || busy !== (i < 10)) begin
            n_fail++; $display("FAIL wrap_flags%0d got done=%b busy=%b", i, done, busy);
         end
      end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL wrap_done_once got=%b exp=0", done); end
      load(8'hFF);
      start = 1'b1; mode = 2'b01; shamt = 4'd0;
      tick();
      start = 1'b0; mode = 2'b00;
      n_cmp++; if (busy !== 1'b0 || q !== 8'hFF || done !== 1'b1) begin
         n_fail++; $display("FAIL zero_shamt got busy=%b q=%h done=%b exp 0 ff 1", busy, q, done);
      end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_shamt_after got done=%b busy=%b exp 0 0", done, busy);
      end
   endtask

   task automatic test_abort();
      load(8'hF0);
      start = 1'b1; mode = 2'b01; rot = 1'b0; ser_in = 1'b0; shamt = 4'd6;
      tick();
      start = 1'b0; en = 1'b1; mode = 2'b11; d = 8'h00;
      tick();
      n_cmp++; if (q !== 8'h78) begin n_fail++; $display("FAIL abort_step1 got=%h exp=78", q); end
      tick();
      n_cmp++; if (q !== 8'h3C) begin n_fail++; $display("FAIL abort_step2 got=%h exp=3c", q); end
      abort = 1'b1;
      tick();
      abort = 1'b0; en = 1'b0; mode = 2'b00;
      n_cmp++; if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL abort_edge got q=%h busy=%b done=%b exp 3c 0 0", q, busy, done);
      end
      tick();
      n_cmp++; if (q !== 8'h3C || done !== 1'b0) begin
         n_fail++; $display("FAIL abort_after got q=%h done=%b exp 3c 0", q, done);
      end
   endtask

   task automatic test_back_to_back();
      load(8'h01);
      start = 1'b1; mode = 2'b10; rot = 1'b1; shamt = 4'd9;
      tick();
      for (int i = 0; i < 9; i++) tick();
      n_cmp++; if (q !== 8'h02 || done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_first got q=%h done=%b busy=%b exp 02 1 0", q, done, busy);
      end
      tick();
      start = 1'b0; mode = 2'b00; rot = 1'b0;
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h02) begin
         n_fail++; $display("FAIL b2b_restart got busy=%b done=%b q=%h exp 1 0 02", busy, done, q);
      end
      for (int i = 0; i < 9; i++) tick();
      n_cmp++; if (q !== 8'h04 || done !== 1'b1) begin
         n_fail++; $display("FAIL b2b_second got q=%h done=%b exp 04 1", q, done);
      end
      tick();
   endtask

   task automatic test_async_reset();
      load(8'hF0);
      start = 1'b1; mode = 2'b01; rot = 1'b0; ser_in = 1'b0; shamt = 4'd6;
      tick();
      start = 1'b0; mode = 2'b00;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (q !== 8'h00 || busy !== 1'b0) begin
         n_fail++; $display("FAIL arst_immediate got q=%h busy=%b exp 00 0", q, busy);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin
            n_fail++; $display("FAIL arst_after%0d got done=%b busy=%b q=%h exp 0 0 00", i, done, busy, q);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_seq_rotate();
      test_seq_wrap();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
